// File: rtl/riscv_bus_arbiter_if.sv
// riscv_bus_arbiter_if
//   Bundles every bus signal around riscv_bus_arbiter. It covers the fetch read
//   channel (m0_rd_*), the load/store read and write channels (m1_rd_*, m1_wr_*)
//   and the shared single-port memory slave (s_*).
//   Modports:
//     master : arbiter view. It takes the master requests, returns grants and
//              read data, and masters the shared slave.
//     slave  : environment view. The cores drive requests and the memory drives
//              s_gnt/s_rdata.
interface riscv_bus_arbiter_if #(
    parameter int unsigned AW = 32,
    parameter int unsigned DW = 32
);
    localparam int unsigned BW = DW / 8;

    logic          m0_rd_req;
    logic [AW-1:0] m0_rd_addr;
    logic [BW-1:0] m0_rd_be;
    logic          m0_rd_gnt;
    logic [DW-1:0] m0_rd_data;
    logic          m0_rd_vld;

    logic          m1_rd_req;
    logic [AW-1:0] m1_rd_addr;
    logic [BW-1:0] m1_rd_be;
    logic          m1_rd_gnt;
    logic [DW-1:0] m1_rd_data;
    logic          m1_rd_vld;

    logic          m1_wr_req;
    logic [AW-1:0] m1_wr_addr;
    logic [BW-1:0] m1_wr_be;
    logic [DW-1:0] m1_wr_data;
    logic          m1_wr_gnt;

    logic          s_req;
    logic          s_we;
    logic [AW-1:0] s_addr;
    logic [BW-1:0] s_be;
    logic [DW-1:0] s_wdata;
    logic          s_gnt;
    logic [DW-1:0] s_rdata;

    modport master (
        input  m0_rd_req, m0_rd_addr, m0_rd_be,
        output m0_rd_gnt, m0_rd_data, m0_rd_vld,
        input  m1_rd_req, m1_rd_addr, m1_rd_be,
        output m1_rd_gnt, m1_rd_data, m1_rd_vld,
        input  m1_wr_req, m1_wr_addr, m1_wr_be, m1_wr_data,
        output m1_wr_gnt,
        output s_req, s_we, s_addr, s_be, s_wdata,
        input  s_gnt, s_rdata
    );

    modport slave (
        output m0_rd_req, m0_rd_addr, m0_rd_be,
        input  m0_rd_gnt, m0_rd_data, m0_rd_vld,
        output m1_rd_req, m1_rd_addr, m1_rd_be,
        input  m1_rd_gnt, m1_rd_data, m1_rd_vld,
        output m1_wr_req, m1_wr_addr, m1_wr_be, m1_wr_data,
        input  m1_wr_gnt,
        input  s_req, s_we, s_addr, s_be, s_wdata,
        output s_gnt, s_rdata
    );
endinterface

// File: rtl/riscv_bus_arbiter.sv
// riscv_bus_arbiter
//   Shares one single-port memory slave between the fetch master (m0, read
//   only) and the load/store master (m1, read + write).
//   - Arbitration, slave muxing and grants are all combinational, so a winner
//     is granted in the same cycle it requests.
//   - Read data returns to the owner one cycle after an accepted read.
//   Ports:
//     clk   : clock
//     rst_n : asynchronous active-low reset; all outputs read 0 while it is low
//     bus   : riscv_bus_arbiter_if.master (master channels + shared slave)
//   Parameters: AW address width, DW data width, RR_EN 1 = round-robin,
//   0 = m1 always wins.
module riscv_bus_arbiter #(
    parameter int unsigned AW    = 32,
    parameter int unsigned DW    = 32,
    parameter int unsigned RR_EN = 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    riscv_bus_arbiter_if.master  bus
);
    localparam int unsigned BW = DW / 8;

    logic m1_any;
    logic sel;         // 0 = m0, 1 = m1
    logic req;
    logic sel_wr;      // m1 selected and its write channel wins over its read
    logic accept;

    logic last_owner_q;
    logic rvld_q;
    logic rowner_q;

    always_comb begin
        m1_any = bus.m1_wr_req | bus.m1_rd_req;
        if (bus.m0_rd_req && m1_any) begin
            sel = (RR_EN != 0) ? ~last_owner_q : 1'b1;
        end else begin
            sel = m1_any;
        end
        // Gating with rst_n keeps every output at 0 while reset is held.
        req    = rst_n & (bus.m0_rd_req | m1_any);
        sel_wr = req & sel & bus.m1_wr_req;
        accept = req & bus.s_gnt;
    end

    always_comb begin
        bus.s_req   = req;
        bus.s_we    = sel_wr;
        bus.s_addr  = '0;
        bus.s_be    = '0;
        bus.s_wdata = '0;
        if (req) begin
            if (!sel) begin
                bus.s_addr = bus.m0_rd_addr;
                bus.s_be   = bus.m0_rd_be;
            end else if (bus.m1_wr_req) begin
                bus.s_addr  = bus.m1_wr_addr;
                bus.s_be    = bus.m1_wr_be;
                bus.s_wdata = bus.m1_wr_data;
            end else begin
                bus.s_addr = bus.m1_rd_addr;
                bus.s_be   = bus.m1_rd_be;
            end
        end
    end

    always_comb begin
        bus.m0_rd_gnt = accept & ~sel;
        bus.m1_wr_gnt = accept & sel_wr;
        bus.m1_rd_gnt = accept & sel & ~bus.m1_wr_req;
    end

    always_comb begin
        bus.m0_rd_vld  = rvld_q & ~rowner_q;
        bus.m1_rd_vld  = rvld_q & rowner_q;
        bus.m0_rd_data = bus.m0_rd_vld ? bus.s_rdata : {DW{1'b0}};
        bus.m1_rd_data = bus.m1_rd_vld ? bus.s_rdata : {DW{1'b0}};
    end

    // last_owner resets to 1 so m0 wins the first tie.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_owner_q <= 1'b1;
            rvld_q       <= 1'b0;
            rowner_q     <= 1'b0;
        end else if (accept) begin
            last_owner_q <= sel;
            rvld_q       <= ~sel_wr;
            rowner_q     <= sel;
        end else begin
            rvld_q       <= 1'b0;
        end
    end

    // Unused in this configuration; keeps the byte-lane width visible for readers.
    localparam int unsigned BE_W = BW;
endmodule

// File: tb/tb_riscv_bus_arbiter.sv
// tb_riscv_bus_arbiter
//   Directed bench for riscv_bus_arbiter. One round-robin instance (rr) carries
//   most of the scenarios. A fixed-priority instance (fp) covers RR_EN = 0.
module tb_riscv_bus_arbiter;
    logic clk;
    logic rst_n;
    int   total;
    int   passed;

    riscv_bus_arbiter_if #(.AW(32), .DW(32)) rr ();
    riscv_bus_arbiter_if #(.AW(32), .DW(32)) fp ();

    riscv_bus_arbiter #(.AW(32), .DW(32), .RR_EN(1)) dut_rr (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (rr)
    );

    riscv_bus_arbiter #(.AW(32), .DW(32), .RR_EN(0)) dut_fp (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (fp)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        rr.m0_rd_req = 0; rr.m0_rd_addr = 0; rr.m0_rd_be = 0;
        rr.m1_rd_req = 0; rr.m1_rd_addr = 0; rr.m1_rd_be = 0;
        rr.m1_wr_req = 0; rr.m1_wr_addr = 0; rr.m1_wr_be = 0; rr.m1_wr_data = 0;
        fp.m0_rd_req = 0; fp.m0_rd_addr = 0; fp.m0_rd_be = 0;
        fp.m1_rd_req = 0; fp.m1_rd_addr = 0; fp.m1_rd_be = 0;
        fp.m1_wr_req = 0; fp.m1_wr_addr = 0; fp.m1_wr_be = 0; fp.m1_wr_data = 0;
    endtask

    initial begin
        total  = 0;
        passed = 0;
        rst_n  = 0;
        idle_inputs();
        rr.s_gnt = 1; rr.s_rdata = 32'hDEADBEEF;
        fp.s_gnt = 1; fp.s_rdata = 32'h0;

        // Reset, then idle
        @(negedge clk);
        chk("rst_s_req", {31'd0, rr.s_req}, 0);
        chk("rst_m0_vld", {31'd0, rr.m0_rd_vld}, 0);
        step();
        rst_n = 1;
        @(negedge clk);
        chk("idle_s_req", {31'd0, rr.s_req}, 0);
        chk("idle_s_addr", rr.s_addr, 0);
        chk("idle_gnts", {29'd0, rr.m0_rd_gnt, rr.m1_rd_gnt, rr.m1_wr_gnt}, 0);

        // Single m0 read at 0x100, data one cycle later
        step();
        rr.m0_rd_req = 1; rr.m0_rd_addr = 32'h100; rr.m0_rd_be = 4'hF;
        @(negedge clk);
        chk("m0_gnt", {31'd0, rr.m0_rd_gnt}, 1);
        chk("m0_s_addr", rr.s_addr, 32'h100);
        chk("m0_s_be", {28'd0, rr.s_be}, 32'hF);
        chk("m0_s_we", {31'd0, rr.s_we}, 0);
        step();
        rr.m0_rd_req = 0;
        @(negedge clk);
        chk("m0_vld", {31'd0, rr.m0_rd_vld}, 1);
        chk("m0_data", rr.m0_rd_data, 32'hDEADBEEF);
        chk("m1_vld_quiet", {31'd0, rr.m1_rd_vld}, 0);
        chk("m1_data_zero", rr.m1_rd_data, 0);

        // Round-robin: last owner is m0 so grants go m1, m0, m1, m0
        step();
        rr.m0_rd_req = 1; rr.m0_rd_addr = 32'h10;
        rr.m1_rd_req = 1; rr.m1_rd_addr = 32'h20; rr.m1_rd_be = 4'hF;
        for (int i = 0; i < 4; i++) begin
            rr.s_rdata = 32'h1000 + i;
            @(negedge clk);
            chk("rr_m1_gnt", {31'd0, rr.m1_rd_gnt}, (i % 2 == 0) ? 1 : 0);
            chk("rr_m0_gnt", {31'd0, rr.m0_rd_gnt}, (i % 2 == 0) ? 0 : 1);
            chk("rr_addr", rr.s_addr, (i % 2 == 0) ? 32'h20 : 32'h10);
            if (i > 0) begin
                // previous winner gets data this cycle
                chk("rr_m0_vld", {31'd0, rr.m0_rd_vld}, (i % 2 == 0) ? 1 : 0);
                chk("rr_m1_vld", {31'd0, rr.m1_rd_vld}, (i % 2 == 0) ? 0 : 1);
                chk("rr_data", (i % 2 == 0) ? rr.m0_rd_data : rr.m1_rd_data, 32'h1000 + i);
            end
            step();
        end
        rr.m0_rd_req = 0; rr.m1_rd_req = 0; rr.s_rdata = 32'h5555AAAA;
        @(negedge clk);
        chk("rr_last_m0_vld", {31'd0, rr.m0_rd_vld}, 1);
        chk("rr_last_m0_data", rr.m0_rd_data, 32'h5555AAAA);
        chk("rr_last_m1_vld", {31'd0, rr.m1_rd_vld}, 0);

        // Write and read together: write first, no response for it
        step();
        rr.m1_wr_req = 1; rr.m1_wr_addr = 32'h204; rr.m1_wr_be = 4'b1100;
        rr.m1_wr_data = 32'hABCD0000;
        rr.m1_rd_req = 1; rr.m1_rd_addr = 32'h300;
        @(negedge clk);
        chk("wr_gnt", {31'd0, rr.m1_wr_gnt}, 1);
        chk("wr_rd_gnt_wait", {31'd0, rr.m1_rd_gnt}, 0);
        chk("wr_s_we", {31'd0, rr.s_we}, 1);
        chk("wr_s_be", {28'd0, rr.s_be}, 32'hC);
        chk("wr_s_addr", rr.s_addr, 32'h204);
        chk("wr_s_wdata", rr.s_wdata, 32'hABCD0000);
        step();
        rr.m1_wr_req = 0;
        @(negedge clk);
        chk("wr_then_rd_gnt", {31'd0, rr.m1_rd_gnt}, 1);
        chk("wr_then_s_we", {31'd0, rr.s_we}, 0);
        chk("wr_then_wdata", rr.s_wdata, 0);
        chk("wr_then_addr", rr.s_addr, 32'h300);
        chk("wr_no_vld", {30'd0, rr.m0_rd_vld, rr.m1_rd_vld}, 0);
        step();
        rr.m1_rd_req = 0; rr.s_rdata = 32'h12345678;
        @(negedge clk);
        chk("wr_rd_vld", {31'd0, rr.m1_rd_vld}, 1);
        chk("wr_rd_data", rr.m1_rd_data, 32'h12345678);

        // Slave stall: both request, last owner is m1 so m0 is selected and held
        step();
        rr.s_gnt = 0;
        rr.m0_rd_req = 1; rr.m0_rd_addr = 32'h400;
        rr.m1_rd_req = 1; rr.m1_rd_addr = 32'h440;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("stall_gnts", {29'd0, rr.m0_rd_gnt, rr.m1_rd_gnt, rr.m1_wr_gnt}, 0);
            chk("stall_s_req", {31'd0, rr.s_req}, 1);
            chk("stall_sel_hold", rr.s_addr, 32'h400);
            if (i > 0) chk("stall_no_vld", {30'd0, rr.m0_rd_vld, rr.m1_rd_vld}, 0);
            step();
        end
        rr.s_gnt = 1;
        @(negedge clk);
        chk("stall_release_gnt", {31'd0, rr.m0_rd_gnt}, 1);
        chk("stall_release_m1", {31'd0, rr.m1_rd_gnt}, 0);
        step();
        @(negedge clk);
        chk("after_stall_m1_gnt", {31'd0, rr.m1_rd_gnt}, 1);
        chk("after_stall_m0_vld", {31'd0, rr.m0_rd_vld}, 1);
        step();
        rr.m0_rd_req = 0; rr.m1_rd_req = 0;

        // Reset mid-operation discards the in-flight read
        rr.m0_rd_req = 1; rr.m0_rd_addr = 32'h500;
        @(negedge clk);
        chk("pre_rst_gnt", {31'd0, rr.m0_rd_gnt}, 1);
        step();
        rst_n = 0;
        @(negedge clk);
        chk("inrst_vld", {30'd0, rr.m0_rd_vld, rr.m1_rd_vld}, 0);
        chk("inrst_s_req", {31'd0, rr.s_req}, 0);
        chk("inrst_gnts", {29'd0, rr.m0_rd_gnt, rr.m1_rd_gnt, rr.m1_wr_gnt}, 0);
        chk("inrst_s_addr", rr.s_addr, 0);
        chk("inrst_data", rr.m0_rd_data, 0);
        step();
        rst_n = 1; rr.m0_rd_req = 0;
        @(negedge clk);
        chk("postrst_vld", {30'd0, rr.m0_rd_vld, rr.m1_rd_vld}, 0);
        step();
        // First tie after reset goes to m0
        rr.m0_rd_req = 1; rr.m1_rd_req = 1;
        @(negedge clk);
        chk("postrst_vld2", {30'd0, rr.m0_rd_vld, rr.m1_rd_vld}, 0);
        chk("first_tie_m0", {31'd0, rr.m0_rd_gnt}, 1);
        step();
        rr.m0_rd_req = 0; rr.m1_rd_req = 0;

        // Fixed priority: m1 wins every cycle
        fp.m0_rd_req = 1; fp.m0_rd_addr = 32'h600;
        fp.m1_rd_req = 1; fp.m1_rd_addr = 32'h700;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("fp_m1_gnt", {31'd0, fp.m1_rd_gnt}, 1);
            chk("fp_m0_gnt", {31'd0, fp.m0_rd_gnt}, 0);
            step();
        end
        fp.m1_rd_req = 0;
        @(negedge clk);
        chk("fp_m0_alone", {31'd0, fp.m0_rd_gnt}, 1);
        chk("fp_m0_addr", fp.s_addr, 32'h600);
        step();
        idle_inputs();

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule

// File: doc/riscv_bus_arbiter.md
Name: riscv_bus_arbiter

Overview:
- Shares one single-port memory slave between two dualport-bus masters.
- Master 0 is the instruction fetch (read channel only). Master 1 is the load/store unit (read and write channels).
- The block performs request arbitration, same-cycle grant back to the winner, and routing of read data, which returns one cycle after grant.
- It sits between the core pipeline and the memory/bus slave. Any master stall is derived from req & ~gnt on the master side.

Parameters:
- AW, 32, address width in bits.
- DW, 32, data width in bits; byte-enable width is DW/8.
- RR_EN, 1, 1 = round-robin between masters; 0 = fixed priority with master 1 (data) always winning.

Ports:
- clk  in  1  clock
- rst_n  in  1  reset, asynchronous, active-low
- m0_rd_req  in  1  fetch read request
- m0_rd_addr  in  AW  fetch word address
- m0_rd_be  in  DW/8  fetch byte enables
- m0_rd_gnt  out  1  fetch request accepted this cycle
- m0_rd_data  out  DW  fetch read data
- m0_rd_vld  out  1  m0_rd_data valid this cycle
- m1_rd_req  in  1  load request
- m1_rd_addr  in  AW  load word address
- m1_rd_be  in  DW/8  load byte enables
- m1_rd_gnt  out  1  load accepted
- m1_rd_data  out  DW  load read data
- m1_rd_vld  out  1  m1_rd_data valid
- m1_wr_req  in  1  store request
- m1_wr_addr  in  AW  store word address
- m1_wr_be  in  DW/8  store byte enables
- m1_wr_data  in  DW  store data, lane-aligned
- m1_wr_gnt  out  1  store accepted
- s_req  out  1  slave request
- s_we  out  1  1 = write, 0 = read
- s_addr  out  AW  slave address
- s_be  out  DW/8  slave byte enables
- s_wdata  out  DW  slave write data
- s_gnt  in  1  slave accepts the request this cycle
- s_rdata  in  DW  read data, valid the cycle after an accepted read

Behaviour:
- Reset values:
  - All outputs are 0.
  - last_owner = 1, so master 0 wins the first tie.
  - rvld_q = 0, rowner_q = 0.
  - Reset asserted mid-operation discards any in-flight read; no rd_vld pulses after reset is released.
- Master-1 request: m1_any = m1_wr_req | m1_rd_req. If both are asserted, the write wins and the read waits.
- Selection (combinational, evaluated every cycle):
  - Only one master requesting: that master is selected.
  - Both requesting, RR_EN=1: the master != last_owner is selected.
  - Both requesting, RR_EN=0: master 1 is selected.
  - Neither requesting: s_req = 0 and s_addr, s_be, s_wdata, s_we are all 0.
- Slave drive:
  - s_req = any request.
  - s_addr, s_be, s_we, s_wdata are muxed from the selected channel.
  - s_wdata is 0 unless a write is selected.
- Grants:
  - Only the selected channel's gnt equals s_gnt; every other gnt is 0.
  - Grants are combinational (same cycle, no bubble).
  - Requests without grant may change or drop; there is no lock.
- Accept = s_req & s_gnt. On accept:
  - last_owner <= selected master.
  - rvld_q <= ~s_we.
  - rowner_q <= selected master.
- When no accept occurs: rvld_q <= 0, and last_owner holds.
- Read return, the cycle after an accepted read:
  - The owner's rd_vld = 1 and its rd_data = s_rdata.
  - The non-owner's rd_vld = 0 and rd_data = 0.
- Writes produce no response cycle.
- Pipelining: a new accept may occur in the same cycle as a read return. Throughput is 1 transfer/cycle.
- s_gnt = 0: selection and last_owner hold and all gnt outputs are 0. This holds for any number of cycles.

Test Plan:
- Reset, then idle -> all outputs 0. m0_rd_req=1, addr 0x100, s_gnt=1 -> m0_rd_gnt=1 and s_addr=0x100 in the same cycle. Next cycle m0_rd_vld=1 and m0_rd_data = s_rdata (0xDEADBEEF).
- RR_EN=1, both masters reading continuously, s_gnt=1 -> grants alternate m0, m1, m0, m1. Each rd_vld follows its grant by 1 cycle with correct ownership.
- RR_EN=0, both requesting for 4 cycles -> m1 granted all 4 cycles and m0_rd_gnt stays 0.
- m1_wr_req and m1_rd_req together, wr addr 0x204, be 4'b1100, data 0xABCD0000 -> write granted first with s_we=1, s_be=4'b1100. Read granted on the next cycle. No vld pulse follows the write.
- s_gnt=0 for 3 cycles with m0 requesting -> m0_rd_gnt=0 throughout and last_owner unchanged. Grant occurs in the cycle s_gnt rises.
- Accept a read, then assert rst_n=0 in the next cycle -> m0_rd_vld=0 and every output is 0 during reset. No vld pulse after release.
